// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
//
// Brings the asynchronous rx line into the clock domain through a two-flop
// synchroniser, detects the start bit, samples each bit at its mid-point
// and delivers one byte per frame with a single-cycle valid strobe.
// The baud arithmetic matches the team's 8N1 transmitter.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   rx           in   serial line, idle high, asynchronous to clock
//   data         out  [7:0] last correctly framed byte (LSB received first)
//   valid        out  one-cycle pulse, data updated in the same cycle
//   frame_error  out  one-cycle pulse when the stop bit samples low
//   busy         out  high whenever the FSM is not in IDLE
//
// Handshake: there is no ready. valid is a single-cycle strobe and data holds
// its value until the next valid, so a consumer must capture data on valid.
module uart_rx #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 9600
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int BAUD_DIVIDE = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_DIVIDE = BAUD_DIVIDE / 2;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIVIDE - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_DIVIDE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [15:0] count_q, count_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_error_q, frame_error_d;
  logic        rx_s;

  assign rx_s = sync2_q;

  // Synchroniser resets to the idle (high) line level so reset release
  // never looks like a start edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      count_q       <= 16'd0;
      bit_q         <= 4'd0;
      shift_q       <= 8'h00;
      data_q        <= 8'h00;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    frame_error_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        count_d = 16'd0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        count_d = count_q + 16'd1;
        // Re-check the line at the start-bit mid-point; a high line here
        // means the falling edge was a glitch.
        if (count_q == HALF_LAST) begin
          count_d = 16'd0;
          if (!rx_s) begin
            state_d = S_DATA;
            bit_d   = 4'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        count_d = count_q + 16'd1;
        if (count_q == BAUD_LAST) begin
          count_d = 16'd0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        count_d = count_q + 16'd1;
        // Returning to IDLE at the stop-bit mid-point lets a back-to-back
        // start edge be accepted without any extra idle time.
        if (count_q == BAUD_LAST) begin
          count_d = 16'd0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        // Wait for the line to go high so a held-low line cannot retrigger.
        count_d = 16'd0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        count_d = 16'd0;
      end
    endcase
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int CLK_F  = 1600000;
  localparam int BAUD   = 100000;
  localparam int BIT_T  = 16;
  // Cycle (counted at the negedge after the posedge) on which valid or
  // frame_error is seen, relative to the negedge where the start bit is driven:
  // 2 synchroniser cycles + 1 to E0, then HALF + 9 * BIT.
  localparam int EV_LAT = 3 + 8 + 9 * BIT_T;

  logic       clock;
  logic       reset_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       busy;

  uart_rx #(
    .CLOCK_FREQUENCY(CLK_F),
    .BAUD_RATE      (BAUD)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  localparam int K_BUSY = 0;
  localparam int K_DATA = 1;
  localparam int K_VLD  = 2;
  localparam int K_FE   = 3;

  typedef struct {
    int         at;
    int         kind;
    logic [7:0] exp;
  } chk_t;

  logic [7:0] exp_q[$];
  int         exp_vcyc_q[$];
  int         exp_fcyc_q[$];
  chk_t       chk_q[$];

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] last_good;

  function automatic string kind_name(input int k);
    case (k)
      K_BUSY:  return "busy";
      K_DATA:  return "data";
      K_VLD:   return "valid";
      default: return "frame_error";
    endcase
  endfunction

  task automatic add_chk(input int at, input int kind, input logic [7:0] exp);
    chk_t c;
    c.at   = at;
    c.kind = kind;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic monitor();
    logic [7:0] act;
    logic [7:0] ed;
    int         ec;
    forever begin
      @(negedge clock);
      if (valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid cyc=%0d data=%02h required no valid", cyc, data);
        end else begin
          ed = exp_q.pop_front();
          ec = exp_vcyc_q.pop_front();
          if (data !== ed || cyc != ec) begin
            n_err++;
            $display("FAIL valid_frame data=%02h cyc=%0d required data=%02h cyc=%0d",
                     data, cyc, ed, ec);
          end
        end
      end
      if (frame_error) begin
        n_vec++;
        if (exp_fcyc_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_frame_error cyc=%0d required none", cyc);
        end else begin
          ec = exp_fcyc_q.pop_front();
          if (cyc != ec) begin
            n_err++;
            $display("FAIL frame_error_time cyc=%0d required cyc=%0d", cyc, ec);
          end
        end
      end
      if (valid && frame_error) begin
        n_err++;
        $display("FAIL valid_and_frame_error both high cyc=%0d required exclusive", cyc);
      end
      // Expected strobes that are overdue never arrived.
      if (exp_vcyc_q.size() != 0 && exp_vcyc_q[0] < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_valid cyc=%0d never observed, required data=%02h at cyc=%0d",
                 cyc, exp_q[0], exp_vcyc_q[0]);
        void'(exp_q.pop_front());
        void'(exp_vcyc_q.pop_front());
      end
      if (exp_fcyc_q.size() != 0 && exp_fcyc_q[0] < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_frame_error cyc=%0d never observed, required at cyc=%0d",
                 cyc, exp_fcyc_q[0]);
        void'(exp_fcyc_q.pop_front());
      end
      for (int i = chk_q.size() - 1; i >= 0; i--) begin
        if (chk_q[i].at <= cyc) begin
          case (chk_q[i].kind)
            K_BUSY:  act = {7'd0, busy};
            K_DATA:  act = data;
            K_VLD:   act = {7'd0, valid};
            default: act = {7'd0, frame_error};
          endcase
          n_vec++;
          if (chk_q[i].at != cyc || act !== chk_q[i].exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%02h required=%02h at cyc=%0d",
                     kind_name(chk_q[i].kind), cyc, act, chk_q[i].exp, chk_q[i].at);
          end
          chk_q.delete(i);
        end
      end
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic ev, input logic ef);
    if (ev) begin
      exp_q.push_back(d);
      exp_vcyc_q.push_back(cyc + EV_LAT);
    end
    if (ef) begin
      exp_fcyc_q.push_back(cyc + EV_LAT);
    end
    rx = 1'b0;
    repeat (BIT_T) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_T) @(negedge clock);
    end
    rx = stop_bit;
    repeat (BIT_T) @(negedge clock);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_valid;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int c;
    int h;

    vecs[0] = '{8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'hC3, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h7E, 1'b1, 1'b1, 1'b0};

    fork
      monitor();
    join_none

    // 1. Reset values.
    reset_n   = 1'b0;
    rx        = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge clock);
    add_chk(cyc + 1, K_BUSY, 8'h00);
    add_chk(cyc + 1, K_DATA, 8'h00);
    add_chk(cyc + 1, K_VLD,  8'h00);
    add_chk(cyc + 1, K_FE,   8'h00);
    reset_n = 1'b1;
    idle(5);
    add_chk(cyc + 1, K_BUSY, 8'h00);
    add_chk(cyc + 1, K_DATA, 8'h00);
    idle(5);

    // 2. Single byte with busy window around E0 and the stop sample.
    c = cyc;
    add_chk(c + 2,   K_BUSY, 8'h00);
    add_chk(c + 3,   K_BUSY, 8'h01);
    add_chk(c + EV_LAT - 1, K_BUSY, 8'h01);
    add_chk(c + EV_LAT,     K_BUSY, 8'h00);
    add_chk(c + EV_LAT + 1, K_VLD,  8'h00);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    last_good = 8'hA5;
    add_chk(cyc + 3, K_DATA, last_good);
    idle(10);

    // Table of single frames, each followed by an idle gap and a data-hold check.
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].d, vecs[i].stop, vecs[i].exp_valid, vecs[i].exp_fe);
      if (vecs[i].exp_valid) last_good = vecs[i].d;
      add_chk(cyc + 20, K_DATA, last_good);
      idle(24);
    end

    // 3. Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    last_good = 8'hFF;
    idle(10);

    // 4. Glitch / false start.
    c = cyc;
    add_chk(c + 2,  K_BUSY, 8'h00);
    add_chk(c + 3,  K_BUSY, 8'h01);
    add_chk(c + 10, K_BUSY, 8'h01);
    add_chk(c + 11, K_BUSY, 8'h00);
    add_chk(c + 30, K_DATA, last_good);
    rx = 1'b0;
    repeat (4) @(negedge clock);
    idle(200);

    // 5. Framing error followed by a held-low line.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    h = cyc + 40;
    add_chk(cyc + 10, K_BUSY, 8'h01);
    add_chk(h + 2,    K_BUSY, 8'h01);
    add_chk(h + 3,    K_BUSY, 8'h00);
    add_chk(h + 10,   K_DATA, last_good);
    repeat (40) @(negedge clock);
    idle(30);

    // 6. Sweep of every byte value, back to back.
    for (int i = 0; i < 256; i++) begin
      send_frame(8'(i), 1'b1, 1'b1, 1'b0);
    end
    last_good = 8'hFF;
    add_chk(cyc + 5, K_DATA, last_good);
    idle(20);

    // Reset mid-frame: busy drops without a clock edge, frame never completes.
    c = cyc;
    add_chk(c + 30, K_BUSY, 8'h01);
    rx = 1'b0;
    repeat (BIT_T) @(negedge clock);
    rx = 1'b1;
    repeat (BIT_T) @(negedge clock);
    rx = 1'b0;
    repeat (8) @(negedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    rx      = 1'b1;
    add_chk(cyc, K_BUSY, 8'h00);
    last_good = 8'h00;
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    add_chk(cyc + 2,   K_BUSY, 8'h00);
    add_chk(cyc + 200, K_DATA, last_good);
    idle(220);

    // Final report.
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
